// File: rtl/zombie_lane_ctrl.sv
// Per-lane zombie: spawn, timed walk toward the house, hit-point countdown, death hold, game-over latch.
// Outputs are registered and settle one clk after the triggering input; there is no backpressure, and pause freezes the timers.
module zombie_lane_ctrl #(
  parameter int unsigned MOVE_DIV = 1000000,
  parameter int unsigned STEP     = 1,
  parameter int unsigned MAX_POS  = 520,
  parameter int unsigned HP       = 3,
  parameter int unsigned DIE_CYC  = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spawn,
  input  logic        hit,
  input  logic        pause,
  output logic [10:0] gpos,
  output logic        gstart,
  output logic        killed,
  output logic        reached,
  output logic [3:0]  hp_left
);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_DYING, S_REACHED} state_t;

  localparam logic [23:0] DIV_LAST = 24'(MOVE_DIV - 1);
  localparam logic [24:0] DIE_LAST = 25'(DIE_CYC - 1);
  localparam logic [11:0] POS_LIM  = 12'(MAX_POS);
  localparam logic [11:0] STEP_W   = 12'(STEP);
  localparam logic [10:0] POS_MAX  = 11'(MAX_POS);
  localparam logic [3:0]  HP_INIT  = 4'(HP);

  state_t      state, state_nxt;
  logic [23:0] div, div_nxt;
  logic [24:0] die_cnt, die_cnt_nxt;
  logic [10:0] gpos_nxt, pos_stepped;
  logic [11:0] pos_sum;
  logic [3:0]  hp_nxt;
  logic        killed_nxt, reached_nxt;
  logic        tick, kill;

  // 12-bit add so the saturation compare cannot be fooled by a wrap
  assign pos_sum     = {1'b0, gpos} + STEP_W;
  assign pos_stepped = (pos_sum >= POS_LIM) ? POS_MAX : pos_sum[10:0];
  assign tick        = (state == S_WALK) && !pause && (div == DIV_LAST);
  assign kill        = (state == S_WALK) && hit && (hp_left == 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      div     <= '0;
      die_cnt <= '0;
      gpos    <= '0;
      hp_left <= '0;
      killed  <= 1'b0;
      reached <= 1'b0;
    end else begin
      state   <= state_nxt;
      div     <= div_nxt;
      die_cnt <= die_cnt_nxt;
      gpos    <= gpos_nxt;
      hp_left <= hp_nxt;
      killed  <= killed_nxt;
      reached <= reached_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    div_nxt     = div;
    die_cnt_nxt = die_cnt;
    gpos_nxt    = gpos;
    hp_nxt      = hp_left;
    killed_nxt  = 1'b0;
    reached_nxt = reached;
    case (state)
      S_IDLE: begin
        gpos_nxt = '0;
        if (spawn) begin
          state_nxt = S_WALK;
          hp_nxt    = HP_INIT;
          div_nxt   = '0;
        end
      end
      S_WALK: begin
        if (!pause) div_nxt = tick ? '0 : div + 24'd1;
        if (tick) gpos_nxt = pos_stepped;
        if (hit && hp_left != 4'd0) hp_nxt = hp_left - 4'd1;
        // a kill on the same edge as the final step still counts as a kill
        if (kill) begin
          killed_nxt  = 1'b1;
          die_cnt_nxt = '0;
          state_nxt   = S_DYING;
        end else if (gpos_nxt == POS_MAX) begin
          reached_nxt = 1'b1;
          state_nxt   = S_REACHED;
        end
      end
      S_DYING: begin
        if (!pause) begin
          if (die_cnt == DIE_LAST) begin
            die_cnt_nxt = '0;
            gpos_nxt    = '0;
            state_nxt   = S_IDLE;
          end else begin
            die_cnt_nxt = die_cnt + 25'd1;
          end
        end
      end
      S_REACHED: begin
        gpos_nxt    = POS_MAX;
        reached_nxt = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gstart = (state != S_IDLE);
  end

endmodule

// File: tb/tb_zombie_lane_ctrl.sv
// Bench for zombie_lane_ctrl: directed scenarios then random traffic, every cycle compared with a behavioural lane model.
module tb_zombie_lane_ctrl;

  localparam int MOVE_DIV = 4;
  localparam int STEP     = 2;
  localparam int MAX_POS  = 20;
  localparam int HP       = 3;
  localparam int DIE_CYC  = 5;

  localparam int M_IDLE = 0, M_WALK = 1, M_DYING = 2, M_OVER = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spawn = 1'b0;
  logic        hit = 1'b0;
  logic        pause = 1'b0;
  logic [10:0] gpos;
  logic        gstart;
  logic        killed;
  logic        reached;
  logic [3:0]  hp_left;

  int checks = 0;
  int errors = 0;

  // model state: what the lane is doing, where it is, and its two timers
  int m_mode = M_IDLE;
  int m_pos = 0;
  int m_hp = 0;
  int m_killed = 0;
  int m_reached = 0;
  int m_phase = 0;
  int m_hold = 0;

  zombie_lane_ctrl #(
    .MOVE_DIV(MOVE_DIV), .STEP(STEP), .MAX_POS(MAX_POS), .HP(HP), .DIE_CYC(DIE_CYC)
  ) dut (
    .clk(clk), .rst(rst), .spawn(spawn), .hit(hit), .pause(pause),
    .gpos(gpos), .gstart(gstart), .killed(killed), .reached(reached), .hp_left(hp_left)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit sp, input bit ht, input bit ps, input bit rs);
    bit kill_now;
    m_killed = 0;
    if (rs) begin
      m_mode = M_IDLE; m_pos = 0; m_hp = 0; m_reached = 0; m_phase = 0; m_hold = 0;
      return;
    end
    case (m_mode)
      M_IDLE: if (sp) begin
        m_mode = M_WALK; m_hp = HP; m_pos = 0; m_phase = 0;
      end
      M_WALK: begin
        kill_now = ht && (m_hp == 1);
        if (!ps) begin
          m_phase++;
          if (m_phase == MOVE_DIV) begin
            m_phase = 0;
            m_pos = (m_pos + STEP > MAX_POS) ? MAX_POS : m_pos + STEP;
          end
        end
        if (ht && m_hp > 0) m_hp--;
        if (kill_now) begin
          m_killed = 1; m_hold = 0; m_mode = M_DYING;
        end else if (m_pos == MAX_POS) begin
          m_mode = M_OVER; m_reached = 1;
        end
      end
      M_DYING: if (!ps) begin
        m_hold++;
        if (m_hold == DIE_CYC) begin
          m_mode = M_IDLE; m_pos = 0; m_hold = 0;
        end
      end
      default: ;
    endcase
  endtask

  // one clock: drive, let the edge happen, advance the model, compare away from the edge
  task automatic cycle(input bit sp, input bit ht, input bit ps, input bit rs);
    spawn = sp; hit = ht; pause = ps; rst = rs;
    @(posedge clk);
    model_step(sp, ht, ps, rs);
    #1;
    check_eq("gpos", int'(gpos), m_pos);
    check_eq("gstart", int'(gstart), (m_mode != M_IDLE) ? 1 : 0);
    check_eq("killed", int'(killed), m_killed);
    check_eq("reached", int'(reached), m_reached);
    check_eq("hp_left", int'(hp_left), m_hp);
  endtask

  initial begin
    // 1: reset, spawn, first steps
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    check_eq("rst_gpos", int'(gpos), 0);
    check_eq("rst_gstart", int'(gstart), 0);
    check_eq("rst_hp", int'(hp_left), 0);
    cycle(1, 0, 0, 0);
    check_eq("spawn_gstart", int'(gstart), 1);
    check_eq("spawn_hp", int'(hp_left), 3);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    check_eq("first_step", int'(gpos), 2);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    check_eq("second_step", int'(gpos), 4);

    // 2: walk to the house, terminal state ignores spawn/hit
    for (int i = 0; i < 32; i++) cycle(0, 0, 0, 0);
    check_eq("house_reached", int'(reached), 1);
    check_eq("house_gpos", int'(gpos), 20);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    check_eq("house_hold_gpos", int'(gpos), 20);
    check_eq("house_hold_hp", int'(hp_left), 3);
    cycle(0, 0, 0, 1);
    check_eq("house_rst_reached", int'(reached), 0);
    check_eq("house_rst_gstart", int'(gstart), 0);

    // 3: three hits kill, death hold of DIE_CYC cycles
    cycle(1, 0, 0, 0);
    for (int k = 1; k <= 13; k++) cycle(0, (k == 5 || k == 9 || k == 13), 0, 0);
    check_eq("kill_pulse", int'(killed), 1);
    check_eq("kill_hp", int'(hp_left), 0);
    cycle(0, 0, 0, 0);
    check_eq("kill_pulse_once", int'(killed), 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
    check_eq("dying_visible", int'(gstart), 1);
    cycle(1, 0, 0, 0);
    check_eq("dying_done_gstart", int'(gstart), 0);
    check_eq("dying_done_gpos", int'(gpos), 0);

    // 4: pause freezes movement but not hits
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, (i == 10), 1, 0);
    check_eq("pause_gpos", int'(gpos), 2);
    check_eq("pause_hit", int'(hp_left), 2);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    check_eq("resume_wait", int'(gpos), 2);
    cycle(0, 0, 0, 0);
    check_eq("resume_step", int'(gpos), 4);

    // 5: killing hit on the step that reaches the house
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    for (int k = 1; k <= 40; k++) cycle(0, (k == 1 || k == 2 || k == 40), 0, 0);
    check_eq("race_killed", int'(killed), 1);
    check_eq("race_reached", int'(reached), 0);
    check_eq("race_gpos", int'(gpos), 20);
    cycle(0, 0, 0, 0);
    check_eq("race_dying", int'(gstart), 1);

    // 6: reset during DYING and during WALK
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    for (int k = 1; k <= 3; k++) cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);
    check_eq("rst_dying_gstart", int'(gstart), 0);
    check_eq("rst_dying_killed", int'(killed), 0);
    cycle(1, 0, 0, 0);
    check_eq("respawn_hp", int'(hp_left), 3);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    check_eq("rst_walk_gpos", int'(gpos), 0);
    check_eq("rst_walk_gstart", int'(gstart), 0);

    // random traffic
    for (int i = 0; i < 4000; i++)
      cycle(($urandom_range(99) < 6), ($urandom_range(99) < 8),
            ($urandom_range(99) < 20), ($urandom_range(999) < 8));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zombie_lane_ctrl.md
Name: zombie_lane_ctrl

Overview:
- Per-lane zombie controller. Sits directly upstream of the VGA pixel-address generator.
- Produces the zombie offset `gpos` and the visibility flag `gstart` that the address generator consumes. The zombie is drawn at x = 520-gpos .. 639-gpos in its lane.
- Handles spawn, timed walking, hit-point countdown from bullet collisions, a death-hold interval and the reached-house (game over) condition.
- Top level instantiates one per lane (x4) and a second set for the second zombie wave (x4).

Parameters:
- MOVE_DIV, 1000000, clk cycles per movement step (100 MHz clock gives 100 steps/s); legal range 1..2^24-1.
- STEP, 1, pixels added to gpos per movement tick; legal range 1..15.
- MAX_POS, 520, gpos value at which the zombie reaches the house (left edge x=0).
- HP, 3, hits needed to kill; legal range 1..15.
- DIE_CYC, 25000000, cycles the dead zombie stays visible before clearing; legal range 1..2^25-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- spawn  in  1  single-cycle request to start a zombie in this lane
- hit  in  1  single-cycle bullet-collision pulse from the bullet controller
- pause  in  1  level; freezes the movement divider and the death-hold counter
- gpos  out  11  zombie offset from spawn column, 0..MAX_POS
- gstart  out  1  zombie visible/active (drives the address-generator enable)
- killed  out  1  single-cycle pulse when HP reaches 0
- reached  out  1  sticky flag: zombie reached the house
- hp_left  out  4  remaining hit points (debug/score)

Behaviour:
- All state updates on posedge clk. Reset is synchronous, active-high, and has priority over every other input.
- Reset values: state=IDLE, gpos=0, gstart=0, killed=0, reached=0, hp_left=0, div=0, die_cnt=0.
- IDLE:
  - gstart=0, gpos=0.
  - spawn=1 -> WALK next cycle, with hp_left=HP, gpos=0, div=0.
  - hit is ignored.
- WALK:
  - gstart=1.
  - When pause=0, div increments each cycle. When div==MOVE_DIV-1: div=0 and gpos=min(gpos+STEP, MAX_POS), saturating with no wrap.
  - When pause=1, div and gpos hold.
  - hit=1:
    - If hp_left>1: hp_left -= 1.
    - If hp_left==1: hp_left=0, killed=1 for exactly one cycle, die_cnt=0, go to DYING.
  - hit is honoured even while paused.
  - If the updated gpos equals MAX_POS and no kill occurs in the same cycle: go to REACHED and set reached=1.
  - spawn is ignored in WALK.
- DYING:
  - gstart=1; gpos and hp_left frozen.
  - die_cnt increments when pause=0. When die_cnt==DIE_CYC-1: go to IDLE with gpos=0, gstart=0.
  - hit and spawn are ignored.
- REACHED:
  - gstart=1, gpos=MAX_POS, reached=1.
  - Terminal state; only rst exits it. hit and spawn are ignored.
- Simultaneous events:
  - Move tick and a killing hit in the same cycle: the kill wins and the state goes to DYING. gpos still takes the stepped value, and reached stays 0.
  - Move tick and a non-killing hit: both apply.
- Latency:
  - spawn -> gstart=1 one cycle later.
  - Killing hit -> killed pulse on the next cycle edge (registered output).
- Widths: div is 24 bits and die_cnt is 25 bits. The gpos add is done at 12 bits before the saturation compare, so there is no overflow.
- Reset asserted in any state returns the block to IDLE on the next edge. reached clears.

Test Plan:
Bench parameters: MOVE_DIV=4, STEP=2, MAX_POS=20, HP=3, DIE_CYC=5.
1. rst 3 cycles, then spawn pulse -> gstart=1 the next cycle, hp_left=3, gpos=0; gpos reads 2 after 4 more cycles and 4 after 8.
2. Walk with no hits -> gpos climbs 0,2,...,20 (40 cycles), then reached=1, state REACHED, gpos holds 20. A later spawn or hit causes no change; rst clears everything to 0.
3. Spawn, then hit pulses at cycles 5, 9, 13 -> hp_left 2, 1, 0. killed is high for exactly one cycle after the 3rd hit. gstart stays 1 for 5 cycles, then gstart=0 and gpos=0.
4. Hold pause=1 for 20 cycles mid-walk -> gpos constant. A hit during the pause still decrements hp_left. Releasing pause resumes stepping after 4 cycles.
5. Align the third hit with the tick that moves gpos 18->20 -> killed=1, reached=0, state DYING.
6. Assert rst during DYING and during WALK -> next cycle gstart=0, gpos=0, killed=0. A spawn the following cycle restarts with hp_left=3.
